muldiv_unit: RTL and testbench

Parametrised multi-cycle RISC-V M-extension execution unit with an explicit start/done handshake. It replaces the fixed wait-count stall scheme in the integer ALU path. The core FSM drives `start` from EXECUTE and holds the pipeline while `busy` is high. Width, multiplier pipeline depth and divider bits-per-cycle are configurable, and the unit implements all RV32M/RV64M corner cases, including a divide-by-zero/overflow fast path and abort.

---
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M/RV64M multiply/divide unit with start/done handshake
// Pipelined multiplier, restoring divider (DIV_BITS per edge), divide-by-zero/overflow fast path, kill.
module muldiv_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int NITER = XLEN / DIV_BITS;
  localparam int CMAX  = (NITER > MUL_LATENCY) ? NITER : MUL_LATENCY;
  localparam int CW    = $clog2(CMAX + 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  if (!(XLEN == 32 || XLEN == 64) || MUL_LATENCY < 1 ||
      !(DIV_BITS == 1 || DIV_BITS == 2) || (XLEN % DIV_BITS) != 0) begin : g_bad_param
    $error("muldiv_unit: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_FIN} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [2*XLEN-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
  logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [2*XLEN-1:0] prod, prod_out;
  logic              accept, rs1_neg, rs2_neg, a_sgn, b_sgn, in_div0, in_ovf;
  logic [XLEN-1:0]   abs1, abs2, div_rem_n, div_quo_n, quo_fix, rem_fix;
  logic [XLEN:0]     div_sh, div_diff;

  assign busy   = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done   = (state_q == S_FIN);
  assign result = result_q;
  assign accept = start && !busy && !kill;

  assign rs1_neg = ~op[0] & rs1_val[XLEN-1];
  assign rs2_neg = ~op[0] & rs2_val[XLEN-1];
  assign abs1    = rs1_neg ? -rs1_val : rs1_val;
  assign abs2    = rs2_neg ? -rs2_val : rs2_val;
  assign in_div0 = (rs2_val == '0);
  assign in_ovf  = ~op[0] && (rs1_val == XMIN) && (rs2_val == '1);
  assign a_sgn   = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
  assign b_sgn   = (op[1:0] == 2'b01);

  assign prod    = mul_a_q * mul_b_q;
  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  // Product leaves the operand register and passes MUL_LATENCY-1 stages before the result edge.
  if (MUL_LATENCY == 1) begin : g_pipe0
    assign prod_out = prod;
  end else begin : g_pipe
    localparam int PD = MUL_LATENCY - 1;
    logic [2*XLEN-1:0] pipe_q [PD];
    logic [2*XLEN-1:0] pipe_d [PD];
    always_comb begin
      pipe_d[0] = prod;
      for (int i = 1; i < PD; i++) pipe_d[i] = pipe_q[i-1];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PD; i++) pipe_q[i] <= '0;
      end else begin
        for (int i = 0; i < PD; i++) pipe_q[i] <= pipe_d[i];
      end
    end
    assign prod_out = pipe_q[PD-1];
  end

  // Restoring division on magnitudes: DIV_BITS quotient bits per edge.
  always_comb begin
    div_rem_n = rem_q;
    div_quo_n = quo_q;
    div_sh    = '0;
    div_diff  = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      div_sh   = {div_rem_n, div_quo_n[XLEN-1]};
      div_diff = div_sh - {1'b0, dsr_q};
      if (!div_diff[XLEN]) begin
        div_rem_n = div_diff[XLEN-1:0];
        div_quo_n = {div_quo_n[XLEN-2:0], 1'b1};
      end else begin
        div_rem_n = div_sh[XLEN-1:0];
        div_quo_n = {div_quo_n[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d  = op[1:0];
          cnt_d = '0;
          if (!op[2]) begin
            mul_a_d = {{XLEN{a_sgn & rs1_val[XLEN-1]}}, rs1_val};
            mul_b_d = {{XLEN{b_sgn & rs2_val[XLEN-1]}}, rs2_val};
            state_d = S_MUL;
          end else if (in_div0 || in_ovf) begin
            // Fast path preloads final values so FIX forms the result unchanged.
            quo_d     = in_div0 ? '1 : XMIN;
            rem_d     = in_div0 ? rs1_val : '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = S_FIX;
          end else begin
            rem_d     = '0;
            quo_d     = abs1;
            dsr_d     = abs2;
            neg_quo_d = rs1_neg ^ rs2_neg;
            neg_rem_d = rs1_neg;
            state_d   = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == CW'(MUL_LATENCY - 1)) begin
          state_d  = S_FIN;
          result_d = (op_q == 2'b00) ? prod_out[XLEN-1:0] : prod_out[2*XLEN-1:XLEN];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DIV: begin
        rem_d = div_rem_n;
        quo_d = div_quo_n;
        if (cnt_q == CW'(NITER - 1)) state_d = S_FIX;
        else cnt_d = cnt_q + CW'(1);
      end
      S_FIX: begin
        state_d  = S_FIN;
        result_d = op_q[1] ? rem_fix : quo_fix;
      end
      default: state_d = S_IDLE;
    endcase
    if (kill) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
// Instance dut uses DIV_BITS=1, dut2 uses DIV_BITS=2; both XLEN=32, MUL_LATENCY=2.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start2 = 1'b0, kill = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        busy, done, busy2, done2;
  logic [31:0] result, result2;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .MUL_LATENCY(2), .DIV_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1_val(rs1), .rs2_val(rs2),
    .kill(kill), .busy(busy), .done(done), .result(result)
  );

  muldiv_unit #(.XLEN(32), .MUL_LATENCY(2), .DIV_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op(op), .rs1_val(rs1), .rs2_val(rs2),
    .kill(kill), .busy(busy2), .done(done2), .result(result2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input int which, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op  = o;
    rs1 = a;
    rs2 = b;
    if (which == 2) start2 = 1'b1;
    else start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input int which, output int n);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if ((which == 2) ? done2 : done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_op(input int which, input string tag, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] exp);
    int n;
    start_op(which, o, a, b);
    wait_done(which, n);
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " result"}, 64'((which == 2) ? result2 : result), 64'(exp));
    check({tag, " busy in done cycle"}, 64'((which == 2) ? busy2 : busy), 64'd0);
    @(posedge clk);
    #1;
    check({tag, " done one cycle"}, 64'((which == 2) ? done2 : done), 64'd0);
  endtask

  initial begin
    int n;
    int pulses;
    int gaps;

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1, "MULH", OP_MULH, 32'hFFFF_FFFE, 32'h0000_0003, 2, 32'hFFFF_FFFF);
    do_op(1, "MUL", OP_MUL, 32'hFFFF_FFFE, 32'h0000_0003, 2, 32'hFFFF_FFFA);
    do_op(1, "MULHU", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
    do_op(1, "MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF);

    do_op(1, "DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFD);
    do_op(2, "DIV -7/2 radix4", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 17, 32'hFFFF_FFFD);
    do_op(1, "REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF);
    do_op(1, "REM 7/-2", OP_REM, 32'h0000_0007, 32'hFFFF_FFFE, 33, 32'h0000_0001);

    do_op(1, "DIVU 5/0", OP_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    do_op(1, "REMU 5/0", OP_REMU, 32'd5, 32'd0, 1, 32'h0000_0005);
    do_op(1, "DIV MIN/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    do_op(1, "REM MIN/-1", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000);
    do_op(1, "DIVU MIN/-1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000);

    // Back-to-back: MUL is started in the DIVU done cycle.
    start_op(1, OP_DIVU, 32'd100, 32'd7);
    pulses = 0;
    gaps = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          check("b2b DIVU latency", 64'(i), 64'd33);
          check("b2b DIVU result", 64'(result), 64'd14);
          op = OP_MUL;
          rs1 = 32'd6;
          rs2 = 32'd7;
          start = 1'b1;
        end else begin
          check("b2b MUL edge", 64'(i), 64'd36);
          check("b2b MUL result", 64'(result), 64'd42);
          break;
        end
      end else if (!busy) begin
        gaps++;
      end
    end
    check("b2b done pulses", 64'(pulses), 64'd2);
    check("b2b busy gaps", 64'(gaps), 64'd0);
    @(posedge clk);
    #1;
    check("b2b done drops", 64'(done), 64'd0);

    // Kill at edge 10 of a DIV; a start while busy at edge 5 must be ignored.
    start_op(1, OP_DIV, 32'd100, 32'd7);
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
      if (i == 4) begin
        op = OP_MUL;
        rs1 = 32'd3;
        rs2 = 32'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (i == 9) kill = 1'b1;
    end
    check("busy-start busy held", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill no done before", 64'(pulses), 64'd0);
    check("kill busy", 64'(busy), 64'd0);
    check("kill done", 64'(done), 64'd0);
    check("kill result held", 64'(result), 64'd42);
    do_op(1, "REMU after kill", OP_REMU, 32'd100, 32'd7, 33, 32'd2);

    // Asynchronous reset in the middle of a MUL.
    start_op(1, OP_MUL, 32'd6, 32'd7);
    check("pre-reset busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    check("async reset result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1, "DIVU 9/3 after reset", OP_DIVU, 32'd9, 32'd3, 33, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
